// File: rtl/imem_dmem_port_arbiter_if.sv
// Request/acknowledge and memory-port bundle between the IF/MEM requesters, the memory and the arbiter.
// slave = arbiter side, master = requesters plus memory.
interface imem_dmem_port_arbiter_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_ack;
    logic [DATA_W-1:0] if_rdata;

    logic              dm_req;
    logic              dm_we;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic              dm_ack;
    logic [DATA_W-1:0] dm_rdata;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
        output if_ack, if_rdata, dm_ack, dm_rdata, mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
        input  if_ack, if_rdata, dm_ack, dm_rdata, mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/imem_dmem_port_arbiter.sv
// Single-port memory arbiter between instruction fetch and load/store, data-priority with fetch anti-starvation.
// Optional macro ARB_FLUSH_EN adds if_flush, which cancels an in-flight or pending fetch.
module imem_dmem_port_arbiter #(
    parameter int ADDR_W     = 10,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic clk1,
    input  logic rst,
`ifdef ARB_FLUSH_EN
    input  logic if_flush,
`endif
    output logic busy,
    imem_dmem_port_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t            state;
    logic              grant_if;
    logic              flushed;
    logic [2:0]        lat_cnt;
    logic [3:0]        starve_cnt;

    logic              flush;
    logic              if_elig;
    logic              pick_if;
    logic [ADDR_W-1:0] grant_addr;
    logic [DATA_W-1:0] grant_wdata;

`ifdef ARB_FLUSH_EN
    assign flush = if_flush;
`else
    assign flush = 1'b0;
`endif

    assign if_elig     = bus.if_req & ~flush;
    assign pick_if     = if_elig & (~bus.dm_req | (starve_cnt == 4'(STARVE_MAX)));
    assign grant_addr  = pick_if ? bus.if_addr : bus.dm_addr;
    // A fetch leaves the write-data register untouched.
    assign grant_wdata = pick_if ? bus.mem_wdata : bus.dm_wdata;

    always_ff @(posedge clk1) begin
        if (rst) begin
            state         <= IDLE;
            grant_if      <= 1'b0;
            flushed       <= 1'b0;
            lat_cnt       <= '0;
            starve_cnt    <= '0;
            busy          <= 1'b0;
            bus.if_ack    <= 1'b0;
            bus.if_rdata  <= '0;
            bus.dm_ack    <= 1'b0;
            bus.dm_rdata  <= '0;
            bus.mem_en    <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
        end else begin
            // NOTE: pulse outputs default low here; a later assignment in the case below wins.
            bus.if_ack <= 1'b0;
            bus.dm_ack <= 1'b0;
            bus.mem_en <= 1'b0;
            bus.mem_we <= 1'b0;

            if (state != IDLE && grant_if && flush)
                flushed <= 1'b1;

            case (state)
                IDLE: begin
                    if (if_elig || bus.dm_req) begin
                        state         <= ISSUE;
                        busy          <= 1'b1;
                        grant_if      <= pick_if;
                        flushed       <= 1'b0;
                        bus.mem_en    <= 1'b1;
                        bus.mem_we    <= ~pick_if & bus.dm_we;
                        bus.mem_addr  <= grant_addr;
                        bus.mem_wdata <= grant_wdata;
                        if (pick_if)
                            starve_cnt <= '0;
                        else if (bus.if_req && starve_cnt != 4'(STARVE_MAX))
                            starve_cnt <= starve_cnt + 4'd1;
                    end
                end
                ISSUE: begin
                    if (bus.mem_we) begin
                        state      <= RESP;
                        bus.dm_ack <= 1'b1;
                    end else begin
                        state   <= WAIT;
                        lat_cnt <= 3'(MEM_LAT);
                    end
                end
                WAIT: begin
                    if (lat_cnt == 3'd1) begin
                        state <= RESP;
                        if (!grant_if) begin
                            bus.dm_ack   <= 1'b1;
                            bus.dm_rdata <= bus.mem_rdata;
                        end else if (!(flushed || flush)) begin
                            bus.if_ack   <= 1'b1;
                            bus.if_rdata <= bus.mem_rdata;
                        end
                    end
                    lat_cnt <= lat_cnt - 3'd1;
                end
                RESP: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/imem_dmem_port_arbiter.md
Name: imem_dmem_port_arbiter

Overview:
- Arbitrates the single-ported 1024x32 unified instruction/data memory between two requesters: the IF stage (instruction fetch, read-only) and the MEM stage (load/store).
- The arbiter is a request/acknowledge FSM. It issues one memory access at a time, waits a parameterised memory latency, and returns read data.
- Data accesses have priority over fetches. A starvation counter guarantees fetch progress.

Parameters:
- ADDR_W, 10, memory word-address width (1024 words).
- DATA_W, 32, memory word width.
- MEM_LAT, 1, cycles from the mem_en cycle to valid mem_rdata; legal range 1..7.
- STARVE_MAX, 4, consecutive data grants allowed while if_req is pending before IF is forced; legal range 1..15.

Ports:
- clk1  in  1  sole clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- if_req  in  1  fetch request; held high until if_ack.
- if_addr  in  ADDR_W  fetch word address; stable while if_req is high.
- if_ack  out  1  one-cycle pulse; fetch complete.
- if_rdata  out  DATA_W  fetched word; valid in the if_ack cycle, held until the next if_ack.
- dm_req  in  1  data request; held high until dm_ack.
- dm_we  in  1  1 = store, 0 = load; stable while dm_req is high.
- dm_addr  in  ADDR_W  data word address.
- dm_wdata  in  DATA_W  store data.
- dm_ack  out  1  one-cycle pulse; load or store complete.
- dm_rdata  out  DATA_W  load data; valid in the dm_ack cycle, held until the next load dm_ack.
- mem_en  out  1  memory access strobe, exactly one cycle per transaction.
- mem_we  out  1  write strobe, qualified by mem_en.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data.
- busy  out  1  high whenever the FSM is not IDLE.

Behaviour:
- Reset:
  - All outputs are 0 and the FSM is IDLE. Starvation counter = 0.
  - if_rdata and dm_rdata are cleared.
  - rst overrides every other event.
  - Reset mid-transaction abandons the access. No ack is issued, and mem_en is low in the cycle after the reset edge.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If no request is pending, stay in IDLE.
  - Otherwise select a winner. Register the winner's addr, we and wdata (IF always has we = 0). Go to ISSUE.
- Arbitration:
  - dm_req alone: grant DM. if_req alone: grant IF.
  - Both pending: grant DM unless starve_cnt == STARVE_MAX, in which case grant IF.
- Starvation counter:
  - Increments, saturating, on a DM grant while if_req is high.
  - Clears on any IF grant.
  - Unchanged otherwise.
- ISSUE:
  - mem_en = 1 for exactly this cycle. mem_we = latched we; mem_addr and mem_wdata are the latched values.
  - Store: go to RESP.
  - Read: go to WAIT with lat_cnt = MEM_LAT.
- WAIT:
  - lat_cnt decrements each cycle.
  - In the cycle where lat_cnt reaches 1, mem_rdata is captured into the winner's rdata register. Go to RESP.
- RESP: pulse the winner's ack, then go to IDLE unconditionally. No arbitration is performed in RESP.
- Latency, with request first seen in IDLE at cycle R:
  - mem_en in cycle R+1.
  - Read ack in cycle R+MEM_LAT+2; with MEM_LAT = 1, ack at R+3.
  - Store ack in cycle R+2.
- Requester rules:
  - A requester drops req no later than the cycle after ack. A req still high in the IDLE cycle after ack is treated as a new request.
  - A req deasserted before ack is a protocol violation; behaviour is undefined. The bench checks it with an assertion.
- mem_* outputs:
  - Registered; mem_addr and mem_wdata retain their last value when mem_en = 0.
  - mem_we is 0 whenever mem_en = 0.
- Throughput: at most one transaction per MEM_LAT+3 cycles for reads and per 3 cycles for stores. Back-to-back requests incur one IDLE cycle between transactions.

Optional Feature:
- Macro: ARB_FLUSH_EN.
- When defined, adds port if_flush (in, 1), pulsed on a taken branch.
- Effect of if_flush in a cycle:
  - An in-flight IF transaction completes its memory access, but its if_ack is suppressed and if_rdata is not updated.
  - If the FSM is IDLE in that cycle, IF is not eligible for arbitration.
- DM transactions and the starvation counter are unaffected.
- When undefined: no port is present, and every IF transaction acks.

Test Plan:
- Reset then a single fetch: mem holds 0x0000_0123 at addr 5, if_req/if_addr = 5 at cycle R, MEM_LAT = 1 -> mem_en at R+1, if_ack at R+3, if_rdata = 0x0000_0123. busy = 1 from R+1 to R+3.
- Store then load to addr 0x3FF (wrap-edge address) with wdata 0xDEAD_BEEF -> store: mem_we = 1 at R+1 and dm_ack at R+2. The following load returns dm_rdata = 0xDEAD_BEEF.
- if_req and dm_req held continuously, STARVE_MAX = 4 -> grant order DM, DM, DM, DM, IF, DM, ... and starve_cnt returns to 0 after the IF grant.
- MEM_LAT = 3, read at cycle R -> mem_en at R+1, capture at R+4, ack at R+5. No second mem_en while busy.
- rst asserted in WAIT -> no ack is issued, all outputs are 0 next cycle, and a fresh request afterwards completes normally with starve_cnt = 0.
- ARB_FLUSH_EN defined, if_flush pulsed during WAIT of a fetch -> mem_en still seen, if_ack never asserted, if_rdata unchanged.
